bullet_ctrl: RTL
================

# bullet_ctrl

Player-bullet controller for the Space Invaders game. Takes the fire button, the paddle position and a once-per-frame tick, launches a single bullet from the centre of the paddle, and moves it up the screen until it leaves the top edge or the enemy collision stage reports a hit. It sits between the paddle controller (upstream) and the enemy/collision logic and pixel mixer (downstream). It also produces a registered per-pixel bullet colour for the mixer.

## Interface
Parameters (defaults match the global game parameters):
- HRES, 1280, horizontal resolution in pixels
- VRES, 720, vertical resolution in pixels
- PADDLE_W, 50, paddle width
- PADDLE_H, 20, paddle height
- BULLET_W, 4, bullet width
- BULLET_H, 16, bullet height
- BULLET_SPEED, 16, pixels moved per frame tick
- BULLET_COLOR, 24'hFFFFFF, bullet RGB
- COOLDOWN_FRAMES, 8, frames between bullet retirement and re-arm (0 allowed)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (vblank start)
- fire  in  1  fire button level, already synchronised
- paddle_x  in  11  paddle left edge in pixels
- hit  in  1  one-cycle pulse from collision logic: the bullet struck an enemy
- hcount  in  11  current pixel x
- vcount  in  10  current pixel y
- bullet_x  out  11  bullet left edge
- bullet_y  out  10  bullet top edge
- bullet_active  out  1  bullet is in flight
- bullet_fired  out  1  one-cycle pulse on launch
- bullet_pix  out  1  registered: current pixel lies inside the bullet
- bullet_rgb  out  24  registered: BULLET_COLOR when bullet_pix, else 0

## Operation
- The block uses a three-state FSM: IDLE, FLY, COOLDOWN.
- Fire request: in IDLE, a qualifying fire condition sets the `req` latch. Without the macro, the qualifying condition is a rising edge of `fire` (`fire & ~fire_q`). `req` is ignored and not set in FLY or COOLDOWN.
- IDLE → FLY occurs on `frame_tick` when `req` is set, or a qualifying fire is seen in that same cycle:
  - bullet_x ← paddle_x + (PADDLE_W − BULLET_W)/2, which is +23 with defaults.
  - bullet_y ← VRES − PADDLE_H − BULLET_H, which is 684 with defaults.
  - bullet_active ← 1, bullet_fired pulses, and `req` is cleared.
- FLY, on `frame_tick`:
  - If bullet_y < BULLET_SPEED: retire (active ← 0) and go to COOLDOWN.
  - Otherwise bullet_y ← bullet_y − BULLET_SPEED.
  - bullet_x does not change in flight.
- FLY, on `hit` (any cycle): retire and go to COOLDOWN. If `hit` and `frame_tick` arrive in the same cycle, `hit` wins and there is no move.
- COOLDOWN:
  - On entry, the counter is loaded with COOLDOWN_FRAMES.
  - Each `frame_tick` decrements the counter. The state goes to IDLE on the tick where the counter reaches 0.
  - If COOLDOWN_FRAMES = 0, retirement goes directly to IDLE.
- `hit` outside FLY is ignored.
- Arithmetic is unsigned. The spawn x is not clamped; the paddle controller guarantees paddle_x ≤ HRES − PADDLE_W. The underflow check comes before the subtract, so bullet_y never wraps.
- Render condition: bullet_active && bullet_x ≤ hcount < bullet_x + BULLET_W && bullet_y ≤ vcount < bullet_y + BULLET_H. Comparisons are done at 12/11 bits so the sums cannot overflow.

## Timing
- Reset values: state IDLE, bullet_x 0, bullet_y 0, bullet_active 0, bullet_fired 0, bullet_pix 0, bullet_rgb 0, req 0, fire_q 0, counter 0. Because fire_q resets to 0, a button held through reset release counts as a rising edge.
- Launch: outputs update on the clock edge that samples `frame_tick`. bullet_fired is high for exactly that next cycle.
- Hit: bullet_active is 0 on the cycle after `hit` is sampled.
- Pixel outputs have 1-cycle latency from hcount/vcount and use bullet state as of that same sample.
- Reset mid-flight drops the bullet immediately (asynchronous).

## Configuration
- `BULLET_AUTOFIRE_EN` defined: the qualifying fire condition is the `fire` level. Holding fire relaunches on the first `frame_tick` after COOLDOWN ends.
- Not defined: rising-edge only. A press that lands during FLY or COOLDOWN is lost, and the button must be released and pressed again.

## Test plan
- Reset then fire edge, paddle_x = 100, then `frame_tick` → bullet_fired pulse, bullet_x = 123, bullet_y = 684, active = 1. The next 42 ticks give y = 668 … 12, and the following tick retires the bullet (active = 0).
- In flight, `hit` coincident with `frame_tick` at y = 300 → active = 0 the next cycle, y stays 300, state COOLDOWN. After 8 ticks the state is IDLE.
- Fire edge during FLY and during COOLDOWN (macro off) → no launch after return to IDLE.
- Macro on, fire held high → relaunch on the first tick after cooldown; bullet_fired pulses exactly once per launch.
- Bullet at x = 123, y = 684; sweep hcount 122..127, vcount 683..700 → bullet_pix/rgb = FFFFFF only for x 123..126 and y 684..699, one cycle late.
- COOLDOWN_FRAMES = 0: retire, then fire edge plus tick → launch on that same tick.

Source files
------------

// File: rtl/bullet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bullet_ctrl
//  Purpose  : Player-bullet controller. Launches a single bullet from the
//             centre of the paddle on fire + frame tick, moves it up the
//             screen once per frame, retires it at the top edge or on an
//             enemy hit, then waits a cooldown before re-arming. Also
//             produces a registered per-pixel bullet mask and colour.
//  Build    : define BULLET_AUTOFIRE_EN to qualify fire on the button level
//             (autofire); otherwise only a rising edge of fire counts.
//  Ports    : clk, rst (async, active-high)
//             frame_tick  - one-cycle pulse per frame
//             fire        - synchronised fire button level
//             paddle_x    - paddle left edge
//             hit         - one-cycle pulse, bullet struck an enemy
//             hcount/vcount - current pixel position
//             bullet_x/bullet_y - bullet top-left corner
//             bullet_active - bullet in flight
//             bullet_fired  - one-cycle pulse on launch
//             bullet_pix/bullet_rgb - registered pixel mask / colour
//  Revision : 1.0 - initial release
// ============================================================================
module bullet_ctrl #(
  parameter int          HRES            = 1280,
  parameter int          VRES            = 720,
  parameter int          PADDLE_W        = 50,
  parameter int          PADDLE_H        = 20,
  parameter int          BULLET_W        = 4,
  parameter int          BULLET_H        = 16,
  parameter int          BULLET_SPEED    = 16,
  parameter logic [23:0] BULLET_COLOR    = 24'hFFFFFF,
  parameter int          COOLDOWN_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [10:0] paddle_x,
  input  logic        hit,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [10:0] bullet_x,
  output logic [9:0]  bullet_y,
  output logic        bullet_active,
  output logic        bullet_fired,
  output logic        bullet_pix,
  output logic [23:0] bullet_rgb
);

  localparam int C_X_OFF   = (PADDLE_W - BULLET_W) / 2;
  localparam int C_Y_SPAWN = VRES - PADDLE_H - BULLET_H;
  localparam int C_CNT_W   = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic [10:0]          x_q, x_d;
  logic [9:0]           y_q, y_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 fired_q, fired_d;
  logic                 pix_q;
  logic [23:0]          rgb_q;

  logic                 w_fire_qual;
  logic                 w_pix_d;

  // --------------------------------------------------------------------------
  // Fire qualification
  // --------------------------------------------------------------------------
`ifdef BULLET_AUTOFIRE_EN
  assign w_fire_qual = fire;
`else
  logic fire_q;

  // fire_q resets low, so a button held through reset release is an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q <= 1'b0;
    end else begin
      fire_q <= fire;
    end
  end

  assign w_fire_qual = fire & ~fire_q;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    fired_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A fire seen on the tick cycle itself launches without waiting.
        if (frame_tick && (req_q || w_fire_qual)) begin
          state_d = FLY;
          x_d     = paddle_x + 11'(C_X_OFF);
          y_d     = 10'(C_Y_SPAWN);
          fired_d = 1'b1;
          req_d   = 1'b0;
        end else if (w_fire_qual) begin
          req_d = 1'b1;
        end
      end

      FLY: begin
        // Hit has priority over movement; the underflow test precedes the
        // subtract so y never wraps.
        if (hit || (frame_tick && (y_q < 10'(BULLET_SPEED)))) begin
          if (COOLDOWN_FRAMES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = C_CNT_W'(COOLDOWN_FRAMES);
          end
        end else if (frame_tick) begin
          y_d = y_q - 10'(BULLET_SPEED);
        end
      end

      COOLDOWN: begin
        if (frame_tick) begin
          cnt_d = cnt_q - C_CNT_W'(1);
          if (cnt_q == C_CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pixel render: widened compares so x+W / y+H cannot overflow.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pix_d = (state_q == FLY)
           && ({1'b0, hcount} >= {1'b0, x_q})
           && ({1'b0, hcount} <  ({1'b0, x_q} + 12'(BULLET_W)))
           && ({1'b0, vcount} >= {1'b0, y_q})
           && ({1'b0, vcount} <  ({1'b0, y_q} + 11'(BULLET_H)))
           && ({1'b0, hcount} <  12'(HRES))
           && ({1'b0, vcount} <  11'(VRES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      pix_q <= w_pix_d;
      rgb_q <= w_pix_d ? BULLET_COLOR : 24'h000000;
    end
  end

  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign bullet_active = (state_q == FLY);
  assign bullet_fired  = fired_q;
  assign bullet_pix    = pix_q;
  assign bullet_rgb    = rgb_q;

endmodule
`default_nettype wire
